// File: rtl/tile_fetch.sv
// Tile graphics read initiator: pixel coordinate -> tilemap ROM -> tile ROM -> in-order FWFT output FIFO.
// Credit-based admission reserves a FIFO slot for every entry in the fixed-latency pipe.
module tile_fetch #(
  parameter int TILE_W     = 16,
  parameter int TILE_H     = 16,
  parameter int MAP_COLS   = 64,
  parameter int MAP_ROWS   = 48,
  parameter int IDX_W      = 8,
  parameter int PIX_W      = 8,
  parameter int TYPE_W     = 2,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int X_W        = 11,
  parameter int Y_W        = 10
) (
  input  logic                                                  vclock,
  input  logic                                                  rst,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [X_W-1:0]                                        req_x,
  input  logic [Y_W-1:0]                                        req_y,
  output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0]                  map_addr,
  input  logic [IDX_W-1:0]                                      map_data,
  output logic [IDX_W+$clog2(TILE_H)+$clog2(TILE_W)-1:0]        tile_addr,
  input  logic [PIX_W+TYPE_W:0]                                 tile_data,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [PIX_W-1:0]                                      out_pixel,
  output logic [TYPE_W-1:0]                                     out_type,
  output logic                                                  out_transparent,
  output logic                                                  out_oob
);
  localparam int LOG_W  = $clog2(TILE_W);
  localparam int LOG_H  = $clog2(TILE_H);
  localparam int MAP_AW = $clog2(MAP_COLS*MAP_ROWS);
  localparam int STAGES = 2*MEM_LAT+1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [LOG_H-1:0] row;
    logic [LOG_W-1:0] col;
  } rc_t;

  typedef struct packed {
    logic [PIX_W-1:0]  pixel;
    logic [TYPE_W-1:0] ttype;
    logic              transparent;
    logic              oob;
  } fifo_entry_t;

  // request split
  logic [X_W-1:0] tile_x;
  logic [Y_W-1:0] tile_y;
  logic [31:0]    lin_addr;
  logic           req_oob;
  logic           accept;

  assign tile_x   = req_x >> LOG_W;
  assign tile_y   = req_y >> LOG_H;
  assign lin_addr = 32'(tile_y) * 32'(MAP_COLS) + 32'(tile_x);
  assign req_oob  = (32'(tile_x) >= 32'(MAP_COLS)) || (32'(tile_y) >= 32'(MAP_ROWS));
  assign accept   = req_valid && req_ready;

  // pipe: vld/oob ride to the FIFO, row/col only until tile address formation
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] oob_pipe;
  rc_t             rc_pipe [MEM_LAT:0];

  always_ff @(posedge vclock or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      map_addr  <= '0;
      tile_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept)
        map_addr <= req_oob ? '0 : lin_addr[MAP_AW-1:0];
      if (vld_pipe[MEM_LAT])
        tile_addr <= oob_pipe[MEM_LAT] ? '0
                   : {map_data, rc_pipe[MEM_LAT].row, rc_pipe[MEM_LAT].col};
    end
  end

  always_ff @(posedge vclock) begin
    oob_pipe   <= {oob_pipe[STAGES-1:0], req_oob};
    rc_pipe[0] <= '{row: req_y[LOG_H-1:0], col: req_x[LOG_W-1:0]};
    for (int i = 1; i <= MEM_LAT; i++)
      rc_pipe[i] <= rc_pipe[i-1];
  end

  // output FIFO
  fifo_entry_t        mem [FIFO_DEPTH];
  fifo_entry_t        wr_entry;
  fifo_entry_t        head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count, inflight;
  logic [CNT_W:0]     credit_sum;
  logic               fifo_wr, fifo_pop;

  assign fifo_wr  = vld_pipe[STAGES];
  assign fifo_pop = out_valid && out_ready;
  assign wr_entry = oob_pipe[STAGES] ? '{pixel: '0, ttype: '0, transparent: 1'b1, oob: 1'b1}
                                     : fifo_entry_t'({tile_data, 1'b0});

  always_ff @(posedge vclock) begin
    if (fifo_wr)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge vclock or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({accept, fifo_wr})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // every accepted entry already owns a FIFO slot, so the pipe never stalls
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign req_ready  = rst && (credit_sum < (CNT_W+1)'(FIFO_DEPTH));

  assign out_valid       = (fifo_count != '0);
  assign head            = mem[rd_ptr];
  assign out_pixel       = out_valid ? head.pixel       : '0;
  assign out_type        = out_valid ? head.ttype       : '0;
  assign out_transparent = out_valid ? head.transparent : 1'b0;
  assign out_oob         = out_valid ? head.oob         : 1'b0;
endmodule
